// File: rtl/inst_queue.sv
// Instruction queue between fetch and dispatch.
// Circular buffer of {pc, instruction} pairs. Once a redirect flush has
// left a fetch in flight, the queue discards that one stale response.
module inst_queue #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       imem_resp,
  input  logic [31:0]                imem_rdata,
  input  logic [31:0]                pc_reg,
  input  logic                       imem_outstanding,
  input  logic                       flush,
  input  logic                       deq,
  output logic                       stall_inst,
  output logic                       inst_valid,
  output logic [31:0]                inst_out,
  output logic [31:0]                pc_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [0:0] NORMAL  = 1'b0;
  localparam logic [0:0] DISCARD = 1'b1;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [0:0]    state;
  logic          deq_fire;
  logic          enq_fire;

  // Handshake qualification; a full queue still accepts when the head leaves this cycle
  always_comb begin
    deq_fire = deq && (count != '0) && !flush;
    enq_fire = imem_resp && (state == NORMAL) && !flush &&
               ((count < FULL_CNT) || deq_fire);
  end

  // Pointer and occupancy bookkeeping; flush overrides every other update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq_fire) head <= head + PTR_ONE;
      if (enq_fire) tail <= tail + PTR_ONE;
      if (enq_fire && !deq_fire)      count <= count + CNT_ONE;
      else if (deq_fire && !enq_fire) count <= count - CNT_ONE;
    end
  end

  // Stale-response tracking: drop exactly one response that was in flight at flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NORMAL;
    end else if (flush) begin
      state <= (imem_outstanding && !imem_resp) ? DISCARD : NORMAL;
    end else if ((state == DISCARD) && imem_resp) begin
      state <= NORMAL;
    end
  end

  // Entry storage, intentionally left unreset
  always_ff @(posedge clk) begin
    if (enq_fire) mem[tail] <= {pc_reg, imem_rdata};
  end

  // Head read and status flags from registered state only
  always_comb begin
    inst_valid = (count != '0);
    stall_inst = (count == FULL_CNT);
    pc_out     = mem[head][63:32];
    inst_out   = mem[head][31:0];
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue (DEPTH=16): table-driven start-up
// vectors plus hand-written sequences, checked against a queue scoreboard.
module tb_inst_queue;

  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic [31:0] pc_reg;
  logic        imem_outstanding;
  logic        flush;
  logic        deq;
  logic        stall_inst;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [4:0]  count;

  int n_vec;
  int n_err;

  logic [63:0] sb[$];
  bit          m_discard;

  typedef struct {
    logic        resp;
    logic        dq;
    logic [31:0] pc;
    logic [31:0] data;
    int          exp_count;
    logic        exp_valid;
    logic        exp_stall;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t tbl[4];

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_resp(imem_resp),
    .imem_rdata(imem_rdata),
    .pc_reg(pc_reg),
    .imem_outstanding(imem_outstanding),
    .flush(flush),
    .deq(deq),
    .stall_inst(stall_inst),
    .inst_valid(inst_valid),
    .inst_out(inst_out),
    .pc_out(pc_out),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the scoreboard model
  task automatic check(input string tag);
    cmp({tag, ".count"}, 32'(count), 32'(sb.size()));
    cmp({tag, ".valid"}, 32'(inst_valid), 32'(sb.size() != 0));
    cmp({tag, ".stall"}, 32'(stall_inst), 32'(sb.size() == DEPTH));
    if (sb.size() != 0) begin
      cmp({tag, ".pc"},   pc_out,   sb[0][63:32]);
      cmp({tag, ".inst"}, inst_out, sb[0][31:0]);
    end
  endtask

  // Drive one cycle, update the model at the edge, sample 1ns later
  task automatic step(input logic r, input logic [31:0] p, input logic [31:0] d,
                      input logic o, input logic f, input logic q);
    bit fd;
    bit fe;
    imem_resp        = r;
    pc_reg           = p;
    imem_rdata       = d;
    imem_outstanding = o;
    flush            = f;
    deq              = q;
    @(posedge clk);
    fd = q && (sb.size() > 0) && !f;
    fe = r && !m_discard && !f && ((sb.size() < DEPTH) || fd);
    if (f) begin
      sb.delete();
      m_discard = o && !r;
    end else begin
      if (m_discard && r) m_discard = 1'b0;
      if (fd) void'(sb.pop_front());
      if (fe) sb.push_back({p, d});
    end
    #1;
    imem_resp = 1'b0;
    flush     = 1'b0;
    deq       = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    m_discard = 1'b0;
    #1;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      step(1'b1, base + 32'(4*i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_discard = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0; pc_reg = '0;
    imem_outstanding = 1'b0; flush = 1'b0; deq = 1'b0;
    rst_n = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 32'h6000_0000, 32'h0000_0013, 1, 1'b1, 1'b0, 32'h6000_0000, 32'h0000_0013};
    tbl[1] = '{1'b1, 1'b0, 32'h6000_0004, 32'h0010_0093, 2, 1'b1, 1'b0, 32'h6000_0000, 32'h0000_0013};
    tbl[2] = '{1'b1, 1'b0, 32'h6000_0008, 32'h0020_0113, 3, 1'b1, 1'b0, 32'h6000_0000, 32'h0000_0013};
    tbl[3] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 3, 1'b1, 1'b0, 32'h6000_0000, 32'h0000_0013};

    #3;
    do_reset();

    // Three enqueues, no dequeue
    for (int i = 0; i < 4; i++) begin
      step(tbl[i].resp, tbl[i].pc, tbl[i].data, 1'b0, 1'b0, tbl[i].dq);
      cmp($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].exp_count));
      cmp($sformatf("tbl%0d.valid", i), 32'(inst_valid), 32'(tbl[i].exp_valid));
      cmp($sformatf("tbl%0d.stall", i), 32'(stall_inst), 32'(tbl[i].exp_stall));
      cmp($sformatf("tbl%0d.pc", i), pc_out, tbl[i].exp_pc);
      cmp($sformatf("tbl%0d.inst", i), inst_out, tbl[i].exp_inst);
      check($sformatf("tbl%0d.sb", i));
    end

    // Fill to DEPTH, drop when full, then simultaneous enq+deq at the wrapped tail
    do_reset();
    fill(16, 32'h6100_0000);
    check("full");
    cmp("full.stall_const", 32'(stall_inst), 32'd1);
    cmp("full.count_const", 32'(count), 32'd16);
    step(1'b1, 32'h6DEA_D000, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    check("full.drop");
    step(1'b1, 32'h6200_0000, 32'h0000_1111, 1'b1, 1'b0, 1'b1);
    check("full.enqdeq");
    cmp("full.enqdeq.count", 32'(count), 32'd16);
    cmp("full.enqdeq.head", pc_out, 32'h6100_0004);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      check($sformatf("drain%0d", i));
    end
    cmp("drain.count", 32'(count), 32'd0);

    // Wrap-around with interleaved dequeues
    do_reset();
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 32'h6300_0000 + 32'(4*i), 32'(i * 7), 1'b1, 1'b0, (i % 3) != 0);
      check($sformatf("wrap%0d", i));
    end
    for (int i = 0; i < 40 && sb.size() > 0; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      check($sformatf("wdrain%0d", i));
    end
    cmp("wrap.empty", 32'(count), 32'd0);

    // Flush with a fetch in flight: one stale response dropped
    fill(5, 32'h6400_0000);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    check("flush.discard");
    cmp("flush.count", 32'(count), 32'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    check("discard.idle");
    step(1'b1, 32'h6000_0040, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b0);
    check("discard.drop");
    cmp("discard.drop.valid", 32'(inst_valid), 32'd0);
    step(1'b1, 32'h6000_1000, 32'h0000_0513, 1'b0, 1'b0, 1'b0);
    check("discard.after");
    cmp("discard.after.pc", pc_out, 32'h6000_1000);

    // Flush coincident with a response: word dropped, back to NORMAL
    fill(3, 32'h6500_0000);
    step(1'b1, 32'h6BAD_0000, 32'h1, 1'b1, 1'b1, 1'b0);
    check("flushresp");
    step(1'b1, 32'h6600_0000, 32'h2, 1'b0, 1'b0, 1'b0);
    check("flushresp.next");
    cmp("flushresp.next.pc", pc_out, 32'h6600_0000);

    // Re-flush in DISCARD with nothing in flight returns to NORMAL
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    check("reflush");
    step(1'b1, 32'h6700_0000, 32'h3, 1'b0, 1'b0, 1'b0);
    check("reflush.accept");

    // Asynchronous reset mid-operation
    do_reset();
    fill(7, 32'h6800_0000);
    cmp("pre_async.count", 32'(count), 32'd7);
    #3;
    rst_n = 1'b0;
    sb.delete();
    m_discard = 1'b0;
    #1;
    check("async_rst");
    cmp("async_rst.valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("deq_empty");
    cmp("deq_empty.count", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
